step_phase_decoder: RTL and testbench



---
 rtl/stepper_pkg.sv | 51 +++++
 rtl/step_phase_decoder_if.sv | 25 ++
 rtl/coil_qualifier.sv | 47 ++++
 rtl/step_phase_decoder.sv | 105 ++++++++++
 tb/tb_step_phase_decoder.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/stepper_pkg.sv
// Shared stepper definitions: coil patterns, decoded phases and decoder FSM states.
// Also consumed by the motor drive block.
package stepper_pkg;

    localparam logic [3:0] COIL_P1  = 4'b1100;
    localparam logic [3:0] COIL_P2  = 4'b0110;
    localparam logic [3:0] COIL_P3  = 4'b0011;
    localparam logic [3:0] COIL_P4  = 4'b1001;
    localparam logic [3:0] COIL_OFF = 4'b0000;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_P1      = 3'd1,
        PH_P2      = 3'd2,
        PH_P3      = 3'd3,
        PH_P4      = 3'd4,
        PH_ILLEGAL = 3'd5
    } phase_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } dec_state_t;

    function automatic phase_t decode_coils(input logic [3:0] coils);
        case (coils)
            COIL_OFF: return PH_IDLE;
            COIL_P1:  return PH_P1;
            COIL_P2:  return PH_P2;
            COIL_P3:  return PH_P3;
            COIL_P4:  return PH_P4;
            default:  return PH_ILLEGAL;
        endcase
    endfunction

    // Position within the four-phase cycle, so step direction is a mod-4 difference.
    function automatic logic [1:0] phase_idx(input phase_t p);
        case (p)
            PH_P2:   return 2'd1;
            PH_P3:   return 2'd2;
            PH_P4:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] phase_code(input phase_t p);
        return (p == PH_ILLEGAL) ? 3'd0 : 3'(p);
    endfunction

endpackage

// File: rtl/step_phase_decoder_if.sv
// Coil-feedback bus between the step phase decoder and its rail-control client.
interface step_phase_decoder_if #(
    parameter int POS_W = 14
);
    logic [3:0]              coils_i;
    logic                    clr_pos;
    logic                    clr_fault;
    logic signed [POS_W-1:0] target_i;
    logic signed [POS_W-1:0] pos_o;
    logic                    step_o;
    logic                    dir_o;
    logic [2:0]              phase_o;
    logic                    fault_o;
    logic                    at_target_o;

    modport master (
        output coils_i, clr_pos, clr_fault, target_i,
        input  pos_o, step_o, dir_o, phase_o, fault_o, at_target_o
    );

    modport slave (
        input  coils_i, clr_pos, clr_fault, target_i,
        output pos_o, step_o, dir_o, phase_o, fault_o, at_target_o
    );
endinterface

// File: rtl/coil_qualifier.sv
// Two-flop synchronizer plus stability qualifier for a small group of async lines.
// Emits a one-cycle accept strobe when a new pattern has held STABLE_CYCLES samples.
module coil_qualifier #(
    parameter int STABLE_CYCLES = 4,
    parameter int WIDTH         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] coils,
    output logic [WIDTH-1:0] pattern,
    output logic             accept
);
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync_p0, sync_p1, cand, accepted;
    logic [CNT_W-1:0] cnt, cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (sync_p1 != cand)
            cnt_next = '0;
        else if (cnt != CNT_MAX)
            cnt_next = cnt + CNT_W'(1);
    end

    // Acting on the next count lets the decoder register the step on the same edge.
    assign accept  = (cnt_next == CNT_MAX) && (sync_p1 != accepted);
    assign pattern = accept ? sync_p1 : accepted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0  <= '0;
            sync_p1  <= '0;
            cand     <= '0;
            cnt      <= '0;
            accepted <= '0;
        end else begin
            sync_p0 <= coils;
            sync_p1 <= sync_p0;
            cand    <= sync_p1;
            cnt     <= cnt_next;
            if (accept)
                accepted <= sync_p1;
        end
    end
endmodule

// File: rtl/step_phase_decoder.sv
// Reconstructs signed step position, direction and step strobe from the coil lines,
// and flags illegal or skipped phase sequences with a sticky fault.
module step_phase_decoder
    import stepper_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int POS_W         = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    step_phase_decoder_if.slave  bus
);
    localparam logic signed [POS_W-1:0] ONE = POS_W'(1);

    function automatic logic signed [POS_W-1:0] step_pos(
        input logic signed [POS_W-1:0] p,
        input logic                    up
    );
        return up ? p + ONE : p - ONE;
    endfunction

    logic [3:0]              pattern;
    logic                    accept;
    phase_t                  new_phase, last_phase;
    dec_state_t              state;
    logic signed [POS_W-1:0] pos;
    logic                    step, dir, fault;
    logic [2:0]              phase;
    logic [1:0]              delta;

    coil_qualifier #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .WIDTH         (4)
    ) u_qual (
        .clk     (clk),
        .reset   (reset),
        .coils   (bus.coils_i),
        .pattern (pattern),
        .accept  (accept)
    );

    assign new_phase = decode_coils(pattern);
    assign delta     = phase_idx(new_phase) - phase_idx(last_phase);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_phase <= PH_IDLE;
            pos        <= '0;
            step       <= 1'b0;
            dir        <= 1'b0;
            phase      <= 3'd0;
            fault      <= 1'b0;
        end else begin
            step <= 1'b0;
            if (accept)
                phase <= phase_code(new_phase);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (new_phase == PH_ILLEGAL) begin
                            state <= ST_FAULT;
                            fault <= 1'b1;
                        end else if (new_phase != PH_IDLE) begin
                            state      <= ST_TRACK;
                            last_phase <= new_phase;
                        end
                    end
                end
                ST_TRACK: begin
                    if (accept) begin
                        if (new_phase == PH_IDLE) begin
                            state <= ST_IDLE;
                        end else if (new_phase == PH_ILLEGAL || delta == 2'd2) begin
                            state <= ST_FAULT;
                            fault <= 1'b1;
                        end else begin
                            pos        <= step_pos(pos, delta == 2'd1);
                            dir        <= (delta == 2'd1);
                            step       <= 1'b1;
                            last_phase <= new_phase;
                        end
                    end
                end
                ST_FAULT: begin
                    if (bus.clr_fault) begin
                        state <= ST_IDLE;
                        fault <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Clear has priority over a coincident step; the strobe still fires.
            if (bus.clr_pos)
                pos <= '0;
        end
    end

    assign bus.pos_o       = pos;
    assign bus.step_o      = step;
    assign bus.dir_o       = dir;
    assign bus.phase_o     = phase;
    assign bus.fault_o     = fault;
    assign bus.at_target_o = (pos == bus.target_i);
endmodule

// File: tb/tb_step_phase_decoder.sv
// Directed bench for step_phase_decoder: phase-sequence table plus hand-written
// sequences for glitch rejection, latency, faults, wrap, clear priority and reset.
module tb_step_phase_decoder;
    import stepper_pkg::*;

    localparam int POS_W = 14;

    logic clk;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   step_cnt = 0;
    int   cur_idx = 0;
    int   snap;
    int   first;
    int   pulses;
    logic [3:0] seq [4];

    typedef struct {
        logic [3:0] coils;
        bit         clr;
        int         pos;
        int         dir;
        int         phase;
        int         steps;
    } vec_t;

    vec_t vecs [10];

    step_phase_decoder_if #(.POS_W(POS_W)) bus ();

    step_phase_decoder #(
        .STABLE_CYCLES (4),
        .POS_W         (POS_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.step_o === 1'b1)
            step_cnt <= step_cnt + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pos_now();
        return int'(bus.pos_o);
    endfunction

    task automatic hold(input logic [3:0] c, input int n);
        bus.coils_i = c;
        tick(n);
    endtask

    task automatic fwd(input int n);
        cur_idx = (cur_idx + 1) % 4;
        hold(seq[cur_idx], n);
    endtask

    initial begin
        seq[0] = COIL_P1; seq[1] = COIL_P2; seq[2] = COIL_P3; seq[3] = COIL_P4;
        vecs[0] = '{4'b0000, 1'b0,  0, 0, 0, 0};
        vecs[1] = '{4'b1100, 1'b0,  0, 0, 1, 0};
        vecs[2] = '{4'b0110, 1'b0,  1, 1, 2, 1};
        vecs[3] = '{4'b0011, 1'b0,  2, 1, 3, 1};
        vecs[4] = '{4'b1001, 1'b0,  3, 1, 4, 1};
        vecs[5] = '{4'b1100, 1'b0,  4, 1, 1, 1};
        vecs[6] = '{4'b1001, 1'b1, -1, 0, 4, 1};
        vecs[7] = '{4'b0011, 1'b0, -2, 0, 3, 1};
        vecs[8] = '{4'b0110, 1'b0, -3, 0, 2, 1};
        vecs[9] = '{4'b1100, 1'b0, -4, 0, 1, 1};

        reset         = 1'b1;
        bus.coils_i   = 4'b0000;
        bus.clr_pos   = 1'b0;
        bus.clr_fault = 1'b0;
        bus.target_i  = '0;
        tick(3);
        check("reset_pos",   pos_now(),         0);
        check("reset_step",  int'(bus.step_o),  0);
        check("reset_dir",   int'(bus.dir_o),   0);
        check("reset_phase", int'(bus.phase_o), 0);
        check("reset_fault", int'(bus.fault_o), 0);
        check("reset_at_target", int'(bus.at_target_o), 1);
        reset = 1'b0;
        tick(2);

        // Forward rotation, then reverse rotation after a position clear
        for (int i = 0; i < 10; i++) begin
            snap = step_cnt;
            bus.coils_i = vecs[i].coils;
            if (vecs[i].clr) begin
                bus.clr_pos = 1'b1;
                tick(1);
                bus.clr_pos = 1'b0;
                tick(19);
            end else begin
                tick(20);
            end
            check($sformatf("vec%0d_pos", i),   pos_now(),          vecs[i].pos);
            check($sformatf("vec%0d_dir", i),   int'(bus.dir_o),    vecs[i].dir);
            check($sformatf("vec%0d_phase", i), int'(bus.phase_o),  vecs[i].phase);
            check($sformatf("vec%0d_steps", i), step_cnt - snap,    vecs[i].steps);
            check($sformatf("vec%0d_fault", i), int'(bus.fault_o),  0);
        end
        cur_idx = 0;

        // Short glitch is rejected
        snap = step_cnt;
        hold(COIL_P2, 3);
        hold(COIL_P1, 20);
        check("glitch_steps", step_cnt - snap, 0);
        check("glitch_pos",   pos_now(),       -4);

        // Clean edge: exactly one strobe, six cycles after the edge
        bus.coils_i = COIL_P2;
        first  = -1;
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (bus.step_o === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        check("latency_cycles", first,  6);
        check("latency_pulses", pulses, 1);
        check("latency_pos",    pos_now(), -3);
        check("latency_dir",    int'(bus.dir_o), 1);
        cur_idx = 1;

        // Skipped step and illegal pattern faults, then recovery
        hold(COIL_P1, 20);
        check("ref_p1_pos", pos_now(), -4);
        snap = step_cnt;
        hold(COIL_P3, 20);
        check("skip_fault", int'(bus.fault_o), 1);
        check("skip_pos",   pos_now(),         -4);
        check("skip_phase", int'(bus.phase_o), 3);
        hold(4'b1111, 20);
        check("illegal_fault", int'(bus.fault_o), 1);
        check("illegal_phase", int'(bus.phase_o), 0);
        hold(COIL_P4, 20);
        check("frozen_pos",   pos_now(),         -4);
        check("frozen_phase", int'(bus.phase_o), 4);
        check("frozen_steps", step_cnt - snap,   0);
        bus.clr_fault = 1'b1;
        tick(1);
        bus.clr_fault = 1'b0;
        tick(1);
        check("clr_fault", int'(bus.fault_o), 0);
        snap = step_cnt;
        hold(COIL_P2, 20);
        check("rearm_steps", step_cnt - snap,   0);
        check("rearm_pos",   pos_now(),         -4);
        check("rearm_phase", int'(bus.phase_o), 2);
        hold(COIL_P3, 20);
        check("rearm_step_pos", pos_now(),         -3);
        check("rearm_step_dir", int'(bus.dir_o),   1);
        check("rearm_fault",    int'(bus.fault_o), 0);
        cur_idx = 2;

        // Run up to the positive limit and wrap
        bus.clr_pos = 1'b1;
        tick(1);
        bus.clr_pos = 1'b0;
        tick(1);
        check("clr_pos", pos_now(), 0);
        bus.target_i = 14'sd8191;
        for (int i = 0; i < 8191; i++)
            fwd(7);
        tick(5);
        check("max_pos",       pos_now(),             8191);
        check("max_at_target", int'(bus.at_target_o), 1);
        fwd(20);
        check("wrap_pos",       pos_now(),             -8192);
        check("wrap_at_target", int'(bus.at_target_o), 0);
        cur_idx = (cur_idx + 3) % 4;
        hold(seq[cur_idx], 20);
        check("unwrap_pos",       pos_now(),             8191);
        check("unwrap_dir",       int'(bus.dir_o),       0);
        check("unwrap_at_target", int'(bus.at_target_o), 1);

        // Position clear coinciding with an accepted step
        cur_idx = (cur_idx + 1) % 4;
        bus.coils_i = seq[cur_idx];
        tick(5);
        bus.clr_pos = 1'b1;
        tick(1);
        bus.clr_pos = 1'b0;
        check("clr_vs_step_strobe", int'(bus.step_o), 1);
        check("clr_vs_step_pos",    pos_now(),        0);
        tick(20);
        check("clr_vs_step_hold", pos_now(), 0);

        // Reset mid-run
        for (int i = 0; i < 25; i++)
            fwd(7);
        tick(3);
        check("pre_reset_pos", pos_now(), 25);
        #2 reset = 1'b1;
        #1;
        check("midreset_pos",   pos_now(),         0);
        check("midreset_step",  int'(bus.step_o),  0);
        check("midreset_dir",   int'(bus.dir_o),   0);
        check("midreset_phase", int'(bus.phase_o), 0);
        tick(2);
        reset = 1'b0;
        snap = step_cnt;
        tick(20);
        check("post_reset_steps", step_cnt - snap,   0);
        check("post_reset_pos",   pos_now(),         0);
        check("post_reset_phase", int'(bus.phase_o), cur_idx + 1);
        fwd(20);
        check("post_reset_step_pos", pos_now(),       1);
        check("post_reset_step_dir", int'(bus.dir_o), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
